// File: rtl/jk_pkg.sv
// jk_pkg: JK excitation encodings shared by the counter cells
package jk_pkg;
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_e;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop with synchronous active-low reset
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qm
);
  jk_e jk;
  logic q_d, q_q;
  // JK characteristic equation, with {j,k} taken as the excitation code
  always_comb begin
    jk = jk_e'({j, k});
    q_d = jk == JK_TOGGLE ? ~q_q : jk == JK_SET ? 1'b1 : jk == JK_RESET ? 1'b0 : q_q;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else q_q <= q_d;
  end
  assign q  = q_q;
  assign qm = ~q_q;
endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MOD up/down counter built from JK flip-flop cells
module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qm,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
  logic [WIDTH-1:0] nxt, din_eff, j, k;
  logic ld_ok, illegal, at_end, wrap_d, wrap_q, load_err_d, load_err_q;
  // next state, per-cell excitation and pulse conditions; illegal states fall back to 0
  always_comb begin
    ld_ok      = {1'b0, din} < MOD_X;
    din_eff    = ld_ok ? din : '0;
    illegal    = {1'b0, q} >= MOD_X;
    at_end     = up_dn ? q == TOP : q == '0;
    nxt        = !rst_n ? '0 : load ? din_eff : !en ? q :
                 (illegal || at_end) ? ((illegal || up_dn) ? '0 : TOP) :
                 up_dn ? q + WIDTH'(1) : q - WIDTH'(1);
    j          = !rst_n ? '0 : load ? din_eff : q ^ nxt;
    k          = !rst_n ? '1 : load ? ~din_eff : q ^ nxt;
    tc         = en & ~load & at_end;
    wrap_d     = rst_n & ~load & en & at_end;
    load_err_d = rst_n & load & ~ld_ok;
  end
  // one-cycle pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j[i]),
      .k    (k[i]),
      .q    (q[i]),
      .qm   (qm[i])
    );
  end
endmodule
